// File: rtl/pwm_tim_pkg.sv
// Shared constants and helpers for the PWM timer family.
package pwm_tim_pkg;

  localparam int CNT_W_DEF  = 20;
  localparam int DUTY_W_DEF = 16;
  localparam int MIN_PERIOD = 2;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// 1 us timebase: one tick every CLK_VAL_MHZ cycles, held at zero while stopped.
module pwm_prescaler
  import pwm_tim_pkg::*;
#(
  parameter int CLK_VAL_MHZ = 50
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run,
  output logic tick
);

  localparam int PSC_W = $clog2(CLK_VAL_MHZ);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_VAL_MHZ - 1);

  logic [PSC_W-1:0] psc_q, psc_d;

  always_comb begin
    psc_d = psc_q;
    if (!run || (psc_q == PSC_MAX)) psc_d = '0;
    else                            psc_d = psc_q + 1'b1;
  end

  assign tick = run && (psc_q == PSC_MAX);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) psc_q <= '0;
    else            psc_q <= psc_d;
  end

endmodule

// File: rtl/pwm_multi_tim.sv
// Multi-channel servo PWM: shared frame counter, double-buffered duty and period
// registers that swap only at a frame boundary (or continuously while stopped).
module pwm_multi_tim
  import pwm_tim_pkg::*;
#(
  parameter int CLK_VAL_MHZ = 50,
  parameter int N_CH        = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int PERIOD_US   = 20000
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          run,
  input  logic [CNT_W-1:0]              period_us,
  input  logic                          wr_en,
  input  logic [ch_idx_w(N_CH)-1:0]     wr_ch,
  input  logic [DUTY_W-1:0]             wr_data,
  input  logic [N_CH-1:0]               pol,
  output logic [N_CH-1:0]               pwm,
  output logic                          frame_start
);

  localparam int CH_W = ch_idx_w(N_CH);

  logic              tick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_act_q, per_act_d, per_req;
  logic [DUTY_W-1:0] duty_sh_q  [N_CH];
  logic [DUTY_W-1:0] duty_sh_d  [N_CH];
  logic [DUTY_W-1:0] duty_act_q [N_CH];
  logic [DUTY_W-1:0] duty_act_d [N_CH];
  logic              run_q, fs_q, fs_d;
  logic              boundary, start, load;

  pwm_prescaler #(
    .CLK_VAL_MHZ(CLK_VAL_MHZ)
  ) u_psc (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .run      (run),
    .tick     (tick)
  );

  assign per_req  = (period_us < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_us;
  assign boundary = tick && (cnt_q == (per_act_q - 1'b1));
  assign start    = run && !run_q;
  // Shadow-to-active transfer happens at a boundary, on restart, and every stopped cycle.
  assign load     = !run || boundary || start;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || boundary) cnt_d = '0;
    else if (tick)        cnt_d = cnt_q + 1'b1;
    per_act_d = load ? per_req : per_act_q;
    fs_d      = run && (boundary || start);
    for (int i = 0; i < N_CH; i++) begin
      duty_sh_d[i] = duty_sh_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) duty_sh_d[i] = wr_data;
      // Forwarding through duty_sh_d lets a boundary-cycle write land in the new frame.
      duty_act_d[i] = load ? duty_sh_d[i] : duty_act_q[i];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      per_act_q <= CNT_W'(PERIOD_US);
      run_q     <= 1'b0;
      fs_q      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      per_act_q <= per_act_d;
      run_q     <= run;
      fs_q      <= fs_d;
      for (int i = 0; i < N_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign frame_start = fs_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic act;
    logic pwm_q;

    assign act = run && (cnt_q < CNT_W'(duty_act_q[g]));

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) pwm_q <= 1'b0;
      else            pwm_q <= pol[g] ^ act;
    end

    assign pwm[g] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_tim.sv
// Directed bench for pwm_multi_tim, scaled down: 4 MHz clock, 100 us frames, 5 channels.
module tb_pwm_multi_tim;

  localparam int CLK    = 4;
  localparam int N_CH   = 5;
  localparam int CNT_W  = 12;
  localparam int DUTY_W = 10;
  localparam int PER    = 100;
  localparam int CH_W   = 3;
  localparam int FLEN   = PER * CLK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic [CNT_W-1:0]  period_us;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DUTY_W-1:0] wr_data;
  logic [N_CH-1:0]   pol;
  logic [N_CH-1:0]   pwm;
  logic              frame_start;

  int n_chk = 0;
  int n_err = 0;

  int hi_cnt [N_CH];
  int rises0, first0, fs_mid, fs_end;

  pwm_multi_tim #(
    .CLK_VAL_MHZ(CLK),
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .DUTY_W     (DUTY_W),
    .PERIOD_US  (PER)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .run        (run),
    .period_us  (period_us),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .pol        (pol),
    .pwm        (pwm),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    check(tag, int'(found), 1);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_data = DUTY_W'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Called at the negedge where frame_start is high; samples the len cycles that
  // carry this frame's pwm values, optionally injecting one duty write and one period change.
  task automatic measure(input int len, input int wr_at, input int wch, input int wdat,
                         input int per_at, input int pval);
    logic prev0;
    prev0 = pwm[0];
    for (int i = 0; i < N_CH; i++) hi_cnt[i] = 0;
    rises0 = 0; first0 = -1; fs_mid = 0; fs_end = 0;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) if (pwm[i]) hi_cnt[i]++;
      if (pwm[0] && !prev0) begin
        rises0++;
        if (first0 < 0) first0 = j;
      end
      prev0 = pwm[0];
      if (j < len && frame_start) fs_mid++;
      if (j == len) fs_end = int'(frame_start);
      if (j == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = CH_W'(wch);
        wr_data = DUTY_W'(wdat);
      end else begin
        wr_en = 1'b0;
      end
      if (j == per_at) period_us = CNT_W'(pval);
    end
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
    check({tag, "_ch0"}, hi_cnt[0], e0);
    check({tag, "_ch1"}, hi_cnt[1], e1);
    check({tag, "_ch2"}, hi_cnt[2], e2);
    check({tag, "_ch3"}, hi_cnt[3], e3);
    check({tag, "_ch4"}, hi_cnt[4], e4);
    check({tag, "_fs_end"}, fs_end, 1);
    check({tag, "_fs_mid"}, fs_mid, 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; period_us = CNT_W'(PER);
    wr_en = 1'b0; wr_ch = '0; wr_data = '0; pol = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_fs", int'(frame_start), 0);
    rst_n = 1'b1;

    wait_fs("start_fs");
    wait_fs("first_boundary");
    measure(FLEN, 0, 0, 0, 0, 0);
    check_frame("dflt", 0, 0, 0, 0, 0);

    wr(0, 30); wr(1, 0); wr(2, 100); wr(3, 1);
    wait_fs("after_wr");
    measure(FLEN, 0, 0, 0, 0, 0);
    check_frame("duty", 120, 0, 400, 4, 0);
    check("duty_rises0", rises0, 1);
    check("duty_first0", first0, 1);

    // Mid-frame write: current frame keeps 30 us, next frame gets 20 us.
    measure(FLEN, 50, 0, 20, 0, 0);
    check("mid_ch0", hi_cnt[0], 120);
    check("mid_rises0", rises0, 1);
    // Write in the boundary cycle: the frame that starts there uses it.
    measure(FLEN, FLEN - 1, 0, 10, 0, 0);
    check("next_ch0", hi_cnt[0], 80);
    check("next_rises0", rises0, 1);
    check("next_fs_end", fs_end, 1);

    measure(FLEN, 0, 0, 0, 100, 50);
    check_frame("bnd", 40, 0, 400, 4, 0);
    measure(50 * CLK, 0, 0, 0, 20, 1);
    check_frame("per50", 40, 0, 200, 4, 0);
    measure(2 * CLK, 0, 0, 0, 1, PER);
    check_frame("per2", 8, 0, 8, 4, 0);

    pol = 5'b01010;
    wr(0, 30); wr(1, 30); wr(2, 30); wr(3, 30);
    wr(5, 77); wr(7, 99);
    wait_fs("pol_sync");
    measure(FLEN, 0, 0, 0, 0, 0);
    check_frame("pol", 120, 280, 120, 280, 0);

    repeat (20) @(negedge clk);
    check("stop_pre_pwm0", int'(pwm[0]), 1);
    run = 1'b0;
    @(negedge clk);
    check("stop_pwm", int'(pwm), 5'b01010);
    check("stop_fs", int'(frame_start), 0);
    begin
      int fs_seen;
      fs_seen = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (frame_start) fs_seen++;
      end
      check("stop_fs_silent", fs_seen, 0);
    end
    check("stop_hold_pwm", int'(pwm), 5'b01010);
    run = 1'b1;
    @(negedge clk);
    check("restart_fs", int'(frame_start), 1);
    check("restart_pwm", int'(pwm), 5'b00101);

    wait_fs("restart_boundary");
    repeat (20) @(negedge clk);
    check("rst_pre_pwm0", int'(pwm[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_fs", int'(frame_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_fs", int'(frame_start), 1);
    check("postrst_pwm", int'(pwm), 5'b01010);
    wait_fs("postrst_boundary");
    measure(FLEN, 0, 0, 0, 0, 0);
    check_frame("postrst", 0, 400, 0, 400, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
